// File: rtl/rv32i_types.sv
// Shared RV32I core types. This file holds the memory-arbiter FSM states
// and the requester identities.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_req_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Serializes I-cache line reads and D-cache line reads/writebacks onto one
// physical-memory port. Each response is routed back only to its owner.
module cache_mem_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  // Requests are level-held by the caches until their resp pulse; the memory
  // side holds its strobe until pmem_resp, which completes in that cycle.
  arb_state_t            state, state_nx;
  arb_req_t              last_grant, last_grant_nx;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [LINE_WIDTH-1:0] lat_wdata;
  logic                  take_i, take_d;
  logic                  i_pend, d_pend;

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    take_i        = 1'b0;
    take_d        = 1'b0;
    i_pend        = i_read;
    d_pend        = d_read | d_write;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    i_resp        = 1'b0;
    d_resp        = 1'b0;
    i_rdata       = '0;
    d_rdata       = '0;
    case (state)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        if (i_pend && d_pend) begin
          if (last_grant == ARB_I) take_d = 1'b1;
          else                     take_i = 1'b1;
        end else if (i_pend) begin
          take_i = 1'b1;
        end else if (d_pend) begin
          take_d = 1'b1;
        end
        if (take_i)      state_nx = SERVE_I;
        else if (take_d) state_nx = SERVE_D;
      end
      SERVE_I: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          i_resp        = 1'b1;
          i_rdata       = pmem_rdata;
          state_nx      = RECOVER;
          last_grant_nx = ARB_I;
        end
      end
      SERVE_D: begin
        pmem_read  = ~lat_write;
        pmem_write = lat_write;
        if (pmem_resp) begin
          d_resp        = 1'b1;
          d_rdata       = pmem_rdata;
          state_nx      = RECOVER;
          last_grant_nx = ARB_D;
        end
      end
      RECOVER: begin
        // Blank cycle so a request still high during resp is not re-served.
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign pmem_address = lat_addr;
  assign pmem_wdata   = lat_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= ARB_I;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      if (take_i) begin
        lat_write <= 1'b0;
        lat_addr  <= i_address;
        lat_wdata <= '0;
      end else if (take_d) begin
        lat_write <= d_write;
        lat_addr  <= d_address;
        lat_wdata <= d_wdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: a transaction-level model
// predicts every output each cycle, plus directed literal checks.
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic cmp(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // One outstanding transaction at most; after completion one blank
  // cycle then a full idle cycle must pass before the next grant.
  logic          m_busy, m_owner, m_wr, m_last;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  int            m_gap;
  logic          i_done_evt = 1'b0, d_done_evt = 1'b0;
  logic          grant_q[$];
  logic          want_i, want_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_owner = 1'b0; m_wr = 1'b0; m_last = 1'b0;
      m_addr = '0; m_wdata = '0; m_gap = 0;
    end else if (m_busy) begin
      if (pmem_resp) begin
        m_busy = 1'b0;
        m_gap  = 1;
        m_last = m_owner;
        if (m_owner) d_done_evt = 1'b1;
        else         i_done_evt = 1'b1;
      end
    end else if (m_gap > 0) begin
      m_gap = m_gap - 1;
    end else begin
      want_i = i_read;
      want_d = d_read | d_write;
      if (want_i || want_d) begin
        m_owner = (want_i && want_d) ? ~m_last : want_d;
        m_busy  = 1'b1;
        m_wr    = m_owner & d_write;
        m_addr  = m_owner ? d_address : i_address;
        m_wdata = m_owner ? d_wdata : '0;
        grant_q.push_back(m_owner);
      end
    end
  end

  // ---------------- compare / observe process ----------------
  logic obs_q[$];
  int   i_resp_cnt = 0, d_resp_cnt = 0, rise_cnt = 0;
  int   low_cnt = 0, gap_last = -1;
  logic prev_strobe = 1'b0;
  logic exp_ir, exp_dr;

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      exp_ir = m_busy && !m_owner && pmem_resp;
      exp_dr = m_busy && m_owner && pmem_resp;
      cmp("pmem_read", LW'(pmem_read), LW'(m_busy && !m_wr));
      cmp("pmem_write", LW'(pmem_write), LW'(m_busy && m_wr));
      cmp("i_resp", LW'(i_resp), LW'(exp_ir));
      cmp("d_resp", LW'(d_resp), LW'(exp_dr));
      cmp("i_rdata", i_rdata, exp_ir ? pmem_rdata : '0);
      cmp("d_rdata", d_rdata, exp_dr ? pmem_rdata : '0);
      if (m_busy) cmp("pmem_address", LW'(pmem_address), LW'(m_addr));
      if (m_busy && m_wr) cmp("pmem_wdata", pmem_wdata, m_wdata);
    end
    if (rst_n) begin
      if (i_resp) begin obs_q.push_back(1'b0); i_resp_cnt++; end
      if (d_resp) begin obs_q.push_back(1'b1); d_resp_cnt++; end
      if ((pmem_read | pmem_write) && !prev_strobe) begin
        gap_last = low_cnt;
        rise_cnt++;
      end
      if (pmem_read | pmem_write) low_cnt = 0;
      else                        low_cnt++;
      prev_strobe = pmem_read | pmem_write;
    end
  end

  // ---------------- driver ----------------
  logic          rand_en = 1'b0, spur_en = 1'b0, keep_req = 1'b0;
  int            sticky_mode = 0;
  logic          i_wait = 1'b0, d_wait = 1'b0, i_hold = 1'b0, d_hold = 1'b0;
  int            mem_cnt = -1, mem_lat = 0;
  logic          mem_fix_en = 1'b0;
  logic [LW-1:0] mem_fix_data = '0;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic pick_sticky();
    if (sticky_mode == 2) return 1'($urandom_range(0, 1));
    return sticky_mode == 1;
  endfunction

  task automatic drive_cycle();
    int op;
    // I-cache requester
    if (i_done_evt) begin
      i_done_evt = 1'b0;
      if (!keep_req) begin
        i_wait = 1'b0;
        if (pick_sticky()) i_hold = 1'b1;
        else               i_read = 1'b0;
      end
    end else if (i_hold) begin
      i_hold = 1'b0;
      i_read = 1'b0;
    end else if (rand_en && !i_wait && $urandom_range(0, 3) == 0) begin
      i_read    = 1'b1;
      i_address = $urandom & 32'hFFFF_FFE0;
      i_wait    = 1'b1;
    end else if (rand_en && i_wait && m_busy && !m_owner && $urandom_range(0, 15) == 0) begin
      i_read = 1'b0;
    end
    // D-cache requester
    if (d_done_evt) begin
      d_done_evt = 1'b0;
      if (!keep_req) begin
        d_wait = 1'b0;
        if (pick_sticky()) d_hold = 1'b1;
        else begin d_read = 1'b0; d_write = 1'b0; end
      end
    end else if (d_hold) begin
      d_hold = 1'b0; d_read = 1'b0; d_write = 1'b0;
    end else if (rand_en && !d_wait && $urandom_range(0, 3) == 0) begin
      op        = $urandom_range(0, 2);
      d_read    = (op != 1);
      d_write   = (op != 0);
      d_address = $urandom & 32'hFFFF_FFE0;
      d_wdata   = rand_line();
      d_wait    = 1'b1;
    end else if (rand_en && d_wait && m_busy && m_owner && $urandom_range(0, 15) == 0) begin
      d_read = 1'b0; d_write = 1'b0;
    end
    // memory responder
    if (m_busy) begin
      if (mem_cnt < 0) mem_cnt = rand_en ? $urandom_range(0, 4) : mem_lat;
      if (mem_cnt == 0) begin
        pmem_resp  = 1'b1;
        pmem_rdata = mem_fix_en ? mem_fix_data : rand_line();
        mem_cnt    = -1;
      end else begin
        pmem_resp = 1'b0;
        mem_cnt--;
      end
    end else begin
      pmem_resp  = spur_en && ($urandom_range(0, 7) == 0);
      pmem_rdata = rand_line();
      mem_cnt    = -1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_cycle();
  endtask

  task automatic run_until_idle(input int max_cyc);
    int c = 0;
    while ((i_wait || d_wait || i_hold || d_hold || m_busy || m_gap != 0 ||
            i_read || d_read || d_write) && c < max_cyc) begin
      step();
      c++;
    end
    n_cmp++;
    if (c >= max_cyc) begin
      n_fail++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", c);
    end
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_pmem_read"}, LW'(pmem_read), '0);
    cmp({tag, "_pmem_write"}, LW'(pmem_write), '0);
    cmp({tag, "_pmem_address"}, LW'(pmem_address), '0);
    cmp({tag, "_pmem_wdata"}, pmem_wdata, '0);
    cmp({tag, "_i_resp"}, LW'(i_resp), '0);
    cmp({tag, "_d_resp"}, LW'(d_resp), '0);
    cmp({tag, "_i_rdata"}, i_rdata, '0);
    cmp({tag, "_d_rdata"}, d_rdata, '0);
  endtask

  // Asserts reset mid-cycle with a memory response pending on the bus.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_wait = 1'b0; d_wait = 1'b0; i_hold = 1'b0; d_hold = 1'b0;
    i_done_evt = 1'b0; d_done_evt = 1'b0; keep_req = 1'b0;
    mem_cnt = -1;
    pmem_resp = 1'b1;
    pmem_rdata = {LW/8{8'h5A}};
    #1;
    check_all_zero(tag);
    pmem_resp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [LW-1:0] a5_line, wd_line;
  logic          found;
  int            base;

  initial begin
    a5_line = {LW/8{8'hA5}};
    wd_line = {LW/32{32'h1234_5678}};

    // reset state
    #2;
    do_reset("reset");
    chk_en = 1'b1;

    // tie after reset: D first, then I, two idle cycles between strobes
    step();
    i_read = 1'b1; i_address = 32'h0000_0200; i_wait = 1'b1;
    d_read = 1'b1; d_address = 32'h0000_0400; d_wait = 1'b1;
    mem_lat = 1;
    run_until_idle(60);
    cmp("tie_order_n", LW'(obs_q.size()), LW'(2));
    if (obs_q.size() >= 2) begin
      cmp("tie_first_D", LW'(obs_q[0]), LW'(1));
      cmp("tie_second_I", LW'(obs_q[1]), LW'(0));
    end
    if (grant_q.size() >= 1) cmp("model_tie_first_D", LW'(grant_q[0]), LW'(1));
    cmp("tie_idle_gap", LW'(gap_last), LW'(2));

    // I only: address 0x60, memory answers after 5 cycles with A5 pattern
    obs_q.delete(); grant_q.delete();
    i_read = 1'b1; i_address = 32'h0000_0060; i_wait = 1'b1;
    mem_lat = 4; mem_fix_en = 1'b1; mem_fix_data = a5_line;
    step();
    #1;
    cmp("i_only_pmem_read", LW'(pmem_read), LW'(1));
    cmp("i_only_pmem_address", LW'(pmem_address), LW'(32'h60));
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      #1;
      if (pmem_resp) begin
        found = 1'b1;
        cmp("i_only_resp", LW'(i_resp), LW'(1));
        cmp("i_only_rdata", i_rdata, a5_line);
        cmp("i_only_d_resp", LW'(d_resp), '0);
      end
    end
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL i_only_timeout: no pmem_resp seen, required one"); end
    run_until_idle(40);

    // D write with d_read also high
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_0100; d_wdata = wd_line; d_wait = 1'b1;
    mem_lat = 2; mem_fix_data = rand_line();
    step();
    #1;
    cmp("dw_pmem_write", LW'(pmem_write), LW'(1));
    cmp("dw_pmem_read", LW'(pmem_read), '0);
    cmp("dw_pmem_address", LW'(pmem_address), LW'(32'h100));
    cmp("dw_pmem_wdata", pmem_wdata, wd_line);
    base = d_resp_cnt;
    run_until_idle(40);
    cmp("dw_d_resp_count", LW'(d_resp_cnt - base), LW'(1));
    mem_fix_en = 1'b0;

    // fairness: both held for 4 transactions after reset -> D, I, D, I
    #2;
    do_reset("reset2");
    obs_q.delete(); grant_q.delete();
    step();
    keep_req = 1'b1;
    i_read = 1'b1; i_address = 32'h0000_1000; i_wait = 1'b1;
    d_read = 1'b1; d_address = 32'h0000_2000; d_wait = 1'b1;
    mem_lat = 1;
    for (int c = 0; c < 100 && obs_q.size() < 4; c++) step();
    keep_req = 1'b0;
    i_read = 1'b0; d_read = 1'b0; i_wait = 1'b0; d_wait = 1'b0;
    cmp("fair_count", LW'(obs_q.size()), LW'(4));
    if (obs_q.size() >= 4) begin
      cmp("fair_0_D", LW'(obs_q[0]), LW'(1));
      cmp("fair_1_I", LW'(obs_q[1]), LW'(0));
      cmp("fair_2_D", LW'(obs_q[2]), LW'(1));
      cmp("fair_3_I", LW'(obs_q[3]), LW'(0));
    end
    if (grant_q.size() >= 2) cmp("model_fair_1_I", LW'(grant_q[1]), LW'(0));
    run_until_idle(40);

    // sticky request: i_read kept through the recover cycle -> one transaction
    sticky_mode = 1;
    base = rise_cnt;
    i_read = 1'b1; i_address = 32'h0000_3000; i_wait = 1'b1;
    run_until_idle(40);
    for (int c = 0; c < 6; c++) step();
    cmp("sticky_one_txn", LW'(rise_cnt - base), LW'(1));
    sticky_mode = 0;

    // reset mid-SERVE_D: no d_resp afterwards
    d_read = 1'b1; d_address = 32'h0000_4000; d_wait = 1'b1;
    mem_lat = 20;
    for (int c = 0; c < 3; c++) step();
    cmp("mid_serve_pmem_read", LW'(pmem_read), LW'(1));
    base = d_resp_cnt;
    #2;
    do_reset("mid_reset");
    for (int c = 0; c < 10; c++) step();
    cmp("mid_reset_no_d_resp", LW'(d_resp_cnt - base), '0);
    cmp("mid_reset_idle", LW'(pmem_read | pmem_write), '0);

    // randomized traffic with spurious responses and sticky/dropped requests
    rand_en = 1'b1; spur_en = 1'b1; sticky_mode = 2;
    for (int c = 0; c < 2000; c++) step();
    rand_en = 1'b0;
    run_until_idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
